// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_DEPTH     = 32400;
    localparam int unsigned DEF_BURST_LEN = 16;
    localparam int unsigned DEF_MAX_WAIT  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_C    = 2'd1,
        SEL_D    = 2'd2
    } sel_t;

endpackage

// File: rtl/dmem_arb_rdpipe.sv
// One-cycle read-return stage: remembers who was granted a read and steers
// the RAM read data back to that port (zeroed for out-of-range reads).
module dmem_arb_rdpipe
    import dmem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  sel_t        sel,
    input  logic        is_read,
    input  logic        oob,
    input  logic [31:0] m_rd,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata
);

    sel_t        sel_reg;
    logic        read_reg;
    logic        oob_reg;
    logic [1:0]  rvalid_vec;
    logic [31:0] rdata_arr [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_reg  <= SEL_NONE;
            read_reg <= 1'b0;
            oob_reg  <= 1'b0;
        end else begin
            sel_reg  <= sel;
            read_reg <= is_read && (sel != SEL_NONE);
            oob_reg  <= oob;
        end
    end

    // Index 0 is the CPU port, index 1 the DMA port.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign rvalid_vec[gi] = read_reg && (sel_reg == ((gi == 0) ? SEL_C : SEL_D));
            assign rdata_arr[gi]  = (rvalid_vec[gi] && !oob_reg) ? m_rd : 32'd0;
        end
    endgenerate

    assign c_rvalid = rvalid_vec[0];
    assign c_rdata  = rdata_arr[0];
    assign d_rvalid = rvalid_vec[1];
    assign d_rdata  = rdata_arr[1];

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter in front of the single-port data RAM, with locked DMA
// bursts, address range enforcement and a starvation guard for the DMA.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_burst,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd,
    output logic        err_oob
);

    localparam logic [31:0] DEPTH_V      = 32'(DEPTH);
    localparam logic [7:0]  MAX_WAIT_V   = 8'(MAX_WAIT);
    localparam logic [7:0]  BEATS_INIT_V = 8'(BURST_LEN - 1);

    state_t      state_reg, state_next;
    logic [7:0]  wait_reg, wait_next;
    logic [7:0]  beats_reg, beats_next;
    sel_t        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;
    logic        oob;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            wait_reg  <= 8'd0;
            beats_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            beats_reg <= beats_next;
        end
    end

    // Grant decision; reset suppresses every grant in the same cycle.
    always_comb begin
        sel        = SEL_NONE;
        state_next = state_reg;
        beats_next = beats_reg;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (d_req && (wait_reg == MAX_WAIT_V || !c_req)) begin
                        sel = SEL_D;
                        if (d_burst) begin
                            state_next = BURST;
                            beats_next = BEATS_INIT_V;
                        end
                    end else if (c_req) begin
                        sel = SEL_C;
                    end
                end
                BURST: begin
                    if (d_req) begin
                        sel        = SEL_D;
                        beats_next = beats_reg - 8'd1;
                        if (beats_reg == 8'd1) begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = IDLE;
                        beats_next = 8'd0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        wait_next = 8'd0;
        if (d_req && sel != SEL_D) begin
            wait_next = (wait_reg == MAX_WAIT_V) ? wait_reg : wait_reg + 8'd1;
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = 32'd0;
        sel_wd   = 32'd0;
        case (sel)
            SEL_C: begin
                sel_we   = c_we;
                sel_addr = c_addr;
                sel_wd   = c_wdata;
            end
            SEL_D: begin
                sel_we   = d_we;
                sel_addr = d_addr;
                sel_wd   = d_wdata;
            end
            default: ;
        endcase
    end

    assign oob     = (sel != SEL_NONE) && (sel_addr >= DEPTH_V);
    assign c_gnt   = (sel == SEL_C);
    assign d_gnt   = (sel == SEL_D);
    assign m_we    = sel_we && !oob;
    assign m_addr  = sel_addr;
    assign m_wd    = sel_wd;
    assign err_oob = oob;

    dmem_arb_rdpipe u_rdpipe (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .is_read  (!sel_we),
        .oob      (oob),
        .m_rd     (m_rd),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM model on the m_* port.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        c_gnt, c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req, d_we, d_burst;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_we;
    logic [31:0] m_addr, m_wd, m_rd;
    logic        err_oob;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:32399];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_burst(d_burst), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd),
        .err_oob(err_oob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model; out-of-range reads return a marker the DUT must hide.
    always @(posedge clk) begin
        if (m_we && m_addr < 32'd32400) mem[m_addr] <= m_wd;
        m_rd <= (m_addr < 32'd32400) ? mem[m_addr] : 32'hBAD0BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_burst = 0;
        repeat (3) @(posedge clk);
        #1;
        c_req = 1; c_addr = 32'd10;
        #1;
        $display("step reset: c_gnt=%0d m_addr=%h", c_gnt, m_addr);
        chk("rst_c_gnt", 32'(c_gnt), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_c_rvalid", 32'(c_rvalid), 0);
        chk("rst_err", 32'(err_oob), 0);

        // CPU write then read-back
        next_cycle();
        reset = 0; c_req = 1; c_we = 1; c_addr = 32'd10; c_wdata = 32'hDEADBEEF;
        #1;
        $display("step c_write: c_gnt=%0d m_we=%0d m_addr=%h", c_gnt, m_we, m_addr);
        chk("wr_c_gnt", 32'(c_gnt), 1);
        chk("wr_m_we", 32'(m_we), 1);
        chk("wr_m_addr", m_addr, 32'd10);
        chk("wr_m_wd", m_wd, 32'hDEADBEEF);
        next_cycle();
        c_we = 0;
        #1;
        $display("step c_read: c_gnt=%0d m_we=%0d", c_gnt, m_we);
        chk("rd_c_gnt", 32'(c_gnt), 1);
        chk("rd_m_we", 32'(m_we), 0);
        chk("rd_no_rvalid", 32'(c_rvalid), 0);
        next_cycle();
        c_req = 0;
        #1;
        $display("step c_return: c_rvalid=%0d c_rdata=%h", c_rvalid, c_rdata);
        chk("rd_c_rvalid", 32'(c_rvalid), 1);
        chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
        chk("idle_m_addr", m_addr, 0);

        // Contention: D wins every 9th cycle
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            c_req = 1; c_we = 0; c_addr = 32'd5;
            d_req = 1; d_we = 0; d_addr = 32'd20; d_burst = 0;
            #1;
            $display("step fair %0d: c_gnt=%0d d_gnt=%0d", i, c_gnt, d_gnt);
            chk("fair_d_gnt", 32'(d_gnt), 32'(i % 9 == 8));
            chk("fair_c_gnt", 32'(c_gnt), 32'(i % 9 != 8));
            chk("fair_excl", 32'(c_gnt && d_gnt), 0);
            chk("fair_d_rvalid", 32'(d_rvalid), 32'(i > 0 && (i - 1) % 9 == 8));
            chk("fair_c_rvalid", 32'(c_rvalid), 32'(i > 0 && (i - 1) % 9 != 8));
        end

        // Full 16-beat locked burst with C waiting
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            c_req = (i > 0); c_addr = 32'd6;
            d_req = 1; d_we = 1; d_burst = 1;
            d_addr = 32'd100 + 32'(i); d_wdata = 32'h1000 + 32'(i);
            #1;
            $display("step burst %0d: c_gnt=%0d d_gnt=%0d m_addr=%h", i, c_gnt, d_gnt, m_addr);
            chk("burst_d_gnt", 32'(d_gnt), 1);
            chk("burst_c_gnt", 32'(c_gnt), 0);
            chk("burst_m_we", 32'(m_we), 1);
        end
        next_cycle();
        d_req = 0; d_burst = 0;
        #1;
        $display("step burst_end: c_gnt=%0d d_gnt=%0d", c_gnt, d_gnt);
        chk("burst_end_c_gnt", 32'(c_gnt), 1);
        chk("burst_end_d_gnt", 32'(d_gnt), 0);

        // Burst aborted after 5 beats
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            c_req = (i > 0);
            d_req = 1; d_we = 0; d_burst = 1; d_addr = 32'd100 + 32'(i);
            #1;
            $display("step abort_beat %0d: c_gnt=%0d d_gnt=%0d", i, c_gnt, d_gnt);
            chk("abort_d_gnt", 32'(d_gnt), 1);
            chk("abort_c_gnt", 32'(c_gnt), 0);
        end
        next_cycle();
        d_req = 0; d_burst = 0;
        #1;
        $display("step abort_gap: c_gnt=%0d d_gnt=%0d d_rvalid=%0d d_rdata=%h", c_gnt, d_gnt, d_rvalid, d_rdata);
        chk("abort_gap_c", 32'(c_gnt), 0);
        chk("abort_gap_d", 32'(d_gnt), 0);
        chk("abort_last_rvalid", 32'(d_rvalid), 1);
        chk("abort_last_rdata", d_rdata, 32'h1004);
        next_cycle();
        #1;
        $display("step abort_resume: c_gnt=%0d", c_gnt);
        chk("abort_resume_c", 32'(c_gnt), 1);

        // Address range boundaries
        next_cycle();
        c_req = 1; c_we = 1; c_addr = 32'd32399; c_wdata = 32'h55;
        #1;
        $display("step oob_edge_in: m_we=%0d err_oob=%0d", m_we, err_oob);
        chk("last_in_m_we", 32'(m_we), 1);
        chk("last_in_err", 32'(err_oob), 0);
        next_cycle();
        c_addr = 32'd32400; c_wdata = 32'h1;
        #1;
        $display("step oob_write: c_gnt=%0d m_we=%0d err_oob=%0d", c_gnt, m_we, err_oob);
        chk("oob_wr_gnt", 32'(c_gnt), 1);
        chk("oob_wr_err", 32'(err_oob), 1);
        chk("oob_wr_m_we", 32'(m_we), 0);
        next_cycle();
        c_we = 0; c_addr = 32'd40000;
        #1;
        $display("step oob_read: c_gnt=%0d err_oob=%0d", c_gnt, err_oob);
        chk("oob_rd_gnt", 32'(c_gnt), 1);
        chk("oob_rd_err", 32'(err_oob), 1);
        next_cycle();
        c_addr = 32'd32399;
        #1;
        $display("step oob_return: c_rvalid=%0d c_rdata=%h err_oob=%0d", c_rvalid, c_rdata, err_oob);
        chk("oob_rd_rvalid", 32'(c_rvalid), 1);
        chk("oob_rd_rdata", c_rdata, 0);
        chk("oob_rd_err_clr", 32'(err_oob), 0);
        next_cycle();
        c_req = 0;
        #1;
        $display("step edge_return: c_rvalid=%0d c_rdata=%h", c_rvalid, c_rdata);
        chk("edge_rdata", c_rdata, 32'h55);

        // Reset during beat 3 of a burst
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            c_req = (i > 0); c_addr = 32'd7;
            d_req = 1; d_we = 0; d_burst = 1; d_addr = 32'd300 + 32'(i);
            #1;
            $display("step rst_burst %0d: d_gnt=%0d", i, d_gnt);
            chk("rstb_d_gnt", 32'(d_gnt), 1);
        end
        next_cycle();
        reset = 1; d_addr = 32'd303;
        #1;
        $display("step rst_assert: c_gnt=%0d d_gnt=%0d m_addr=%h", c_gnt, d_gnt, m_addr);
        chk("rstb_no_d", 32'(d_gnt), 0);
        chk("rstb_no_c", 32'(c_gnt), 0);
        chk("rstb_m_addr", m_addr, 0);
        next_cycle();
        #1;
        $display("step rst_hold: d_rvalid=%0d c_rvalid=%0d", d_rvalid, c_rvalid);
        chk("rstb_d_rvalid", 32'(d_rvalid), 0);
        chk("rstb_d_rdata", d_rdata, 0);
        chk("rstb_c_rvalid", 32'(c_rvalid), 0);
        chk("rstb_gnt", 32'(c_gnt || d_gnt), 0);
        next_cycle();
        reset = 0; d_req = 0; d_burst = 0; c_req = 1;
        #1;
        $display("step rst_release: c_gnt=%0d", c_gnt);
        chk("post_rst_c_gnt", 32'(c_gnt), 1);
        next_cycle();
        c_req = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data-memory RAM.
- Port C is the pipeline memory stage. Port D is the image DMA, which loads input pixels and drains the output image.
- Grants at most one access per cycle, enforces the RAM address range, supports locked DMA bursts, and guarantees DMA forward progress under continuous CPU traffic.

Parameters:
- DEPTH, 32400: number of RAM words; valid addresses are 0..DEPTH-1.
- BURST_LEN, 16: beats per locked DMA burst (range 2..256).
- MAX_WAIT, 8: consecutive denied DMA cycles before DMA takes priority (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  CPU access request.
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  32  CPU word address.
- c_wdata  in  32  CPU write data.
- c_gnt  out  1  CPU access accepted this cycle.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  32  CPU read data.
- d_req  in  1  DMA access request.
- d_we  in  1  DMA write/read.
- d_addr  in  32  DMA word address.
- d_wdata  in  32  DMA write data.
- d_burst  in  1  DMA requests a locked burst; sampled only on the first beat.
- d_gnt  out  1  DMA access accepted this cycle.
- d_rvalid  out  1  DMA read data valid.
- d_rdata  out  32  DMA read data.
- m_we  out  1  RAM write enable.
- m_addr  out  32  RAM address.
- m_wd  out  32  RAM write data.
- m_rd  in  32  RAM read data, valid the cycle after m_addr is presented.
- err_oob  out  1  one-cycle pulse: the granted access was out of range.

Behaviour:
- Reset state: all outputs 0, FSM = IDLE, wait counter = 0, beat counter = 0. A reset asserted mid-burst aborts the burst; no further grants until reset deasserts.
- Grants are combinational from the current state and requests. At most one of c_gnt/d_gnt is high in any cycle. A requester holds req and its fields stable until it sees gnt.
- m_addr/m_wd follow the granted port; when there is no grant, both are driven to 0.
- m_we = granted we AND address < DEPTH.
- Read latency: the rvalid of the granted port asserts exactly 1 cycle after a granted read.
  - In range: rdata = m_rd.
  - Out of range: rdata = 0.
  - rdata is 0 whenever rvalid is low.
- Out of range (address >= DEPTH, 32-bit unsigned compare):
  - The access is still granted and consumes the cycle.
  - The write is suppressed.
  - err_oob is high in the grant cycle.
- FSM state IDLE:
  - Default priority is C over D.
  - D wins if the wait counter equals MAX_WAIT.
  - D granted with d_burst=1 goes to state BURST with beats_left = BURST_LEN-1. Otherwise the FSM stays in IDLE.
- FSM state BURST:
  - C is never granted.
  - While d_req=1, D is granted and beats_left decrements; on the grant where beats_left reaches 0, the FSM returns to IDLE.
  - If d_req=0 in any BURST cycle, the burst is aborted and the FSM returns to IDLE the next cycle; there is no grant that cycle.
- Wait counter:
  - Increments (saturating at MAX_WAIT) in each cycle with d_req=1 and d_gnt=0.
  - Clears on d_gnt or when d_req=0.
- Simultaneous C and D requests with the counter below MAX_WAIT: C wins.
- The rvalid pipeline is independent of the FSM. A read granted on the last burst beat still returns its rvalid the following cycle, even if C is granted in that same cycle.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, BURST};
  - port-select enum {SEL_NONE, SEL_C, SEL_D};
  - default constants DEPTH/BURST_LEN/MAX_WAIT.
- One sub-module, dmem_arb_rdpipe: a one-cycle register of {sel, is_read, oob} that produces c_rvalid/d_rvalid and the rdata steering.

Test Plan:
- Reset, then C writes 0xDEADBEEF to address 10 and reads it back -> c_gnt in the request cycles; m_we=1 once; c_rvalid one cycle after the read grant with c_rdata=0xDEADBEEF.
- C and D both request continuously with MAX_WAIT=8 -> C granted 8 cycles, then D granted on the 9th; the pattern repeats; d_gnt and c_gnt are never high together.
- D burst with d_burst=1, BURST_LEN=16, C requesting throughout -> 16 consecutive d_gnt; c_gnt=0 throughout; C granted on the cycle after the 16th beat.
- D deasserts d_req after 5 burst beats -> one idle cycle, FSM returns to IDLE, pending C request granted the following cycle.
- C write to address 32400 with data 0x1 -> c_gnt=1, err_oob=1, m_we=0. A read of 40000 -> c_rvalid=1, c_rdata=0, err_oob=1.
- Reset asserted on beat 3 of a burst -> all outputs 0 next cycle; after release, C request granted immediately.
